e203_ifu_pcgen: RTL
===================

Name: e203_ifu_pcgen

Overview:
- Next-PC generation and fetch-request sequencer of the IFU, directly downstream of the lite branch predictor.
- Consumes the predictor's taken flag, wait/stall flag and adder operands, together with pipeline flush requests from commit.
- Owns the PC register, the next-PC adder and the fetch-request handshake toward the ifetch/ICB interface.
- Allows at most one outstanding fetch; hands each returned instruction to mini-decode/IR.

Parameters:
- PC_SIZE, 32, PC and fetch-address width.
- RESET_VEC, 32'h0000_1000, first fetch address after reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- prdt_taken  in  1  predictor: branch/jump predicted taken
- bpu_wait  in  1  predictor: hold next-PC generation (JALR dependency)
- prdt_pc_add_op1  in  PC_SIZE  predictor adder operand 1
- prdt_pc_add_op2  in  PC_SIZE  predictor adder operand 2
- pipe_flush_req  in  1  commit: redirect request
- pipe_flush_add_op1  in  PC_SIZE  flush target operand 1
- pipe_flush_add_op2  in  PC_SIZE  flush target operand 2
- pipe_flush_ack  out  1  flush accepted
- ifu_req_valid  out  1  fetch request valid
- ifu_req_ready  in  1  fetch request accepted
- ifu_req_pc  out  PC_SIZE  fetch address
- ifu_rsp_valid  in  1  fetched instruction valid
- ifu_rsp_ready  out  1  response accepted
- ifu_rsp_instr16  in  1  returned instruction is 16-bit
- dec_i_valid  out  1  instruction presented to decode/BPU this cycle
- pc  out  PC_SIZE  PC of instruction presented to decode
- halt_req  in  1  debug/WFI halt request (optional feature)
- halt_ack  out  1  IFU quiescent and halted (optional feature)

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous and active-high, port rst.
- Reset values: state=S_REQ, pc_r=RESET_VEC, ifu_req_pc=RESET_VEC, drop_r=0, dec_i_valid=0, pipe_flush_ack=0, halt_ack=0. ifu_req_valid rises in the first cycle after rst deasserts.
- States:
  - S_REQ: ifu_req_valid=1, ifu_req_pc=pc_nxt_r. On ifu_req_ready -> S_WAIT; pc_r<=pc_nxt_r.
  - S_WAIT: one request outstanding. ifu_rsp_ready=1. On ifu_rsp_valid: if drop_r, discard, clear drop_r, -> S_REQ. Else dec_i_valid=1 combinationally in that cycle, pc=pc_r, then:
    - if bpu_wait, -> S_STALL;
    - else pc_nxt_r <= prdt_taken ? op1+op2 : pc_r+(ifu_rsp_instr16?2:4), -> S_REQ.
  - S_STALL: instruction is held; dec_i_valid=1, pc=pc_r, re-evaluated every cycle. When bpu_wait=0, compute pc_nxt_r as above, -> S_REQ.
  - S_HALT: only with the optional feature.
- Adders: modulo 2^PC_SIZE, carry discarded, bit 0 forced to 0.
- Flush:
  - pipe_flush_ack=1 in every non-reset cycle; pipe_flush_req is never back-pressured.
  - Target = flush_op1+flush_op2 (same width rules) and it overrides any prediction-based update in the same cycle.
  - From S_REQ before the handshake: ifu_req_pc switches to the target next cycle. A request already accepted in the flush cycle still completes.
  - From S_WAIT without a same-cycle response: set drop_r. The stale response is consumed with dec_i_valid=0.
  - From S_WAIT with a same-cycle response: dec_i_valid is forced 0, -> S_REQ.
  - From S_STALL: -> S_REQ with dec_i_valid=0 from the next cycle.
- ifu_req_valid, once asserted, stays high until ifu_req_ready; ifu_req_pc changes only on flush.
- Simultaneous flush and prdt_taken: flush wins.
- Reset asserted mid-transaction: any outstanding response is ignored; restart from RESET_VEC.

Optional Feature:
- Macro: E203_CFG_IFU_HALT_EN.
- Defined:
  - halt_req is sampled in S_REQ before a handshake, or on completion of S_WAIT/S_STALL; either -> S_HALT.
  - In S_HALT: ifu_req_valid=0, halt_ack=1.
  - Deasserting halt_req -> S_REQ at pc_nxt_r.
  - Flush in S_HALT updates pc_nxt_r but stays halted.
- Undefined: halt_req ignored, halt_ack tied 0, S_HALT absent.

Test Plan:
- Reset release, ifu_req_ready=1, response 32-bit, prdt_taken=0 -> request PCs 0x1000, 0x1004, 0x1008; dec_i_valid one cycle per response.
- Response with ifu_rsp_instr16=1 at pc 0x1004 -> next ifu_req_pc=0x1006.
- prdt_taken=1, op1=0x1010, op2=0xFFFF_FFF0 -> next ifu_req_pc=0x1000.
- bpu_wait=1 for 3 cycles on a response -> dec_i_valid held 4 cycles with pc constant; no request until bpu_wait=0; then request at op1+op2.
- pipe_flush_req (target 0x2000) while in S_WAIT, response 2 cycles later -> that response dropped (dec_i_valid=0); next request 0x2000.
- With E203_CFG_IFU_HALT_EN, halt_req in S_REQ before ready -> halt_ack=1, ifu_req_valid=0; release -> fetch resumes at the held PC.

Source files
------------

// File: rtl/e203_ifu_pcgen_if.sv
// ============================================================================
// e203_ifu_pcgen_if : fetch request/response bus between PC generator and ifetch
// Rev 1.0
// ============================================================================
`default_nettype none

interface e203_ifu_pcgen_if #(
  parameter int PC_SIZE = 32
);
  logic               ifu_req_valid;
  logic               ifu_req_ready;
  logic [PC_SIZE-1:0] ifu_req_pc;
  logic               ifu_rsp_valid;
  logic               ifu_rsp_ready;
  logic               ifu_rsp_instr16;

  modport master (
    output ifu_req_valid, ifu_req_pc, ifu_rsp_ready,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_instr16
  );

  modport slave (
    input  ifu_req_valid, ifu_req_pc, ifu_rsp_ready,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_instr16
  );
endinterface

`default_nettype wire

// File: rtl/e203_ifu_pcgen.sv
// ============================================================================
// e203_ifu_pcgen : next-PC generation and single-outstanding fetch sequencer
// Optional halt support: define E203_CFG_IFU_HALT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module e203_ifu_pcgen #(
  parameter int               PC_SIZE   = 32,
  parameter logic [PC_SIZE-1:0] RESET_VEC = 32'h0000_1000
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               prdt_taken,
  input  wire logic               bpu_wait,
  input  wire logic [PC_SIZE-1:0] prdt_pc_add_op1,
  input  wire logic [PC_SIZE-1:0] prdt_pc_add_op2,
  input  wire logic               pipe_flush_req,
  input  wire logic [PC_SIZE-1:0] pipe_flush_add_op1,
  input  wire logic [PC_SIZE-1:0] pipe_flush_add_op2,
  output logic                    pipe_flush_ack,
  output logic                    dec_i_valid,
  output logic [PC_SIZE-1:0]      pc,
  input  wire logic               halt_req,
  output logic                    halt_ack,
  e203_ifu_pcgen_if.master        ifu
);

`ifdef E203_CFG_IFU_HALT_EN
  typedef enum logic [1:0] {S_REQ = 2'd0, S_WAIT = 2'd1, S_STALL = 2'd2, S_HALT = 2'd3} state_e;
`else
  typedef enum logic [1:0] {S_REQ = 2'd0, S_WAIT = 2'd1, S_STALL = 2'd2} state_e;
  logic unused_halt_req;
  assign unused_halt_req = halt_req;
`endif

  state_e             state_q, state_d;
  logic [PC_SIZE-1:0] pc_q, pc_d;
  logic [PC_SIZE-1:0] pc_nxt_q, pc_nxt_d;
  logic               drop_q, drop_d;
  logic               instr16_q, instr16_d;

  logic               req_valid, rsp_ready, dec_valid, halted;
  logic               seq_instr16;
  logic [PC_SIZE-1:0] flush_tgt, prdt_tgt, seq_tgt, pred_nxt;

  function automatic logic [PC_SIZE-1:0] add_even(input logic [PC_SIZE-1:0] a,
                                                  input logic [PC_SIZE-1:0] b);
    logic [PC_SIZE-1:0] s;
    s    = a + b;
    s[0] = 1'b0;
    return s;
  endfunction

  // A stalled instruction has already left the bus, so its size comes from the latch.
  assign seq_instr16 = (state_q == S_STALL) ? instr16_q : ifu.ifu_rsp_instr16;
  assign flush_tgt   = add_even(pipe_flush_add_op1, pipe_flush_add_op2);
  assign prdt_tgt    = add_even(prdt_pc_add_op1, prdt_pc_add_op2);
  assign seq_tgt     = add_even(pc_q, seq_instr16 ? PC_SIZE'(2) : PC_SIZE'(4));
  assign pred_nxt    = prdt_taken ? prdt_tgt : seq_tgt;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pc_nxt_d  = pc_nxt_q;
    drop_d    = drop_q;
    instr16_d = instr16_q;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    dec_valid = 1'b0;
    halted    = 1'b0;
    case (state_q)
      S_REQ: begin
        req_valid = 1'b1;
        if (pipe_flush_req) pc_nxt_d = flush_tgt;
        if (ifu.ifu_req_ready) begin
          state_d = S_WAIT;
          pc_d    = pc_nxt_q;
          // The accepted request now fetches from the old stream; discard its reply.
          if (pipe_flush_req) drop_d = 1'b1;
        end
`ifdef E203_CFG_IFU_HALT_EN
        else if (halt_req) state_d = S_HALT;
`endif
      end
      S_WAIT: begin
        rsp_ready = 1'b1;
        if (ifu.ifu_rsp_valid) begin
          instr16_d = ifu.ifu_rsp_instr16;
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
            if (pipe_flush_req) pc_nxt_d = flush_tgt;
          end else if (pipe_flush_req) begin
            pc_nxt_d = flush_tgt;
            state_d  = S_REQ;
          end else begin
            dec_valid = 1'b1;
            if (bpu_wait) begin
              state_d = S_STALL;
            end else begin
              pc_nxt_d = pred_nxt;
              state_d  = S_REQ;
            end
          end
`ifdef E203_CFG_IFU_HALT_EN
          if ((state_d == S_REQ) && halt_req) state_d = S_HALT;
`endif
        end else if (pipe_flush_req) begin
          drop_d   = 1'b1;
          pc_nxt_d = flush_tgt;
        end
      end
      S_STALL: begin
        dec_valid = 1'b1;
        if (pipe_flush_req) begin
          pc_nxt_d = flush_tgt;
          state_d  = S_REQ;
        end else if (!bpu_wait) begin
          pc_nxt_d = pred_nxt;
          state_d  = S_REQ;
        end
`ifdef E203_CFG_IFU_HALT_EN
        if ((state_d == S_REQ) && halt_req) state_d = S_HALT;
`endif
      end
`ifdef E203_CFG_IFU_HALT_EN
      S_HALT: begin
        halted = 1'b1;
        if (pipe_flush_req) pc_nxt_d = flush_tgt;
        if (!halt_req) state_d = S_REQ;
      end
`endif
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_VEC;
      pc_nxt_q  <= RESET_VEC;
      drop_q    <= 1'b0;
      instr16_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pc_nxt_q  <= pc_nxt_d;
      drop_q    <= drop_d;
      instr16_q <= instr16_d;
    end
  end

  // Outputs are masked while reset is held so nothing leaks from a stale state.
  assign ifu.ifu_req_valid = req_valid & ~rst;
  assign ifu.ifu_req_pc    = pc_nxt_q;
  assign ifu.ifu_rsp_ready = rsp_ready & ~rst;
  assign dec_i_valid       = dec_valid & ~rst;
  assign pc                = pc_q;
  assign pipe_flush_ack    = ~rst;
  assign halt_ack          = halted & ~rst;

endmodule

`default_nettype wire
